rbe_normquant_packer: RTL and testbench

Packs the stream of quantized outputs from the normalization/quantization stage into fixed-width output words for the output streamer. Each accepted element contributes its `qa_out` least-significant bits, packed LSB-first. The block sits between the normquant array output and the output stream, and converts per-element values into dense memory words. Element flow uses valid/ready handshakes on both sides, and an explicit last marker flushes a partial word.

---
 rtl/rbe_normquant_packer.sv | 244 ++++++++++++++++++++++++
 tb/tb_rbe_normquant_packer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbe_normquant_packer.sv
// rbe_normquant_packer: packs qa-bit quantized elements LSB-first into
// OUT_WIDTH-bit output words with valid/ready on both sides. A last marker
// flushes a partial word with a reduced byte strobe.
// Optional feature macro: RBE_NORMQUANT_PACKER_OVF_EN (sticky overflow flag
// when an accepted element carries set bits above qa).

package rbe_package;
  localparam int unsigned ACCUMULATOR_SIZE = 32;
endpackage

module rbe_normquant_packer #(
  parameter int unsigned ACC       = rbe_package::ACCUMULATOR_SIZE,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [3:0]             qa_out_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [ACC-1:0]         in_data_i,
  input  logic                   in_last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OUT_WIDTH-1:0]   out_data_o,
  output logic [OUT_WIDTH/8-1:0] out_strb_o,
  output logic                   out_last_o,
  output logic                   busy_o,
  output logic                   cfg_err_o,
  output logic                   ovf_o
);

  // SW holds any bit position or byte count up to OUT_WIDTH itself.
  localparam int unsigned SW = $clog2(OUT_WIDTH) + 1;
  // Fill counter must reach OUT_WIDTH/2-1 (qa=2 is the densest packing).
  localparam int unsigned CW = $clog2(OUT_WIDTH / 2);
  localparam int unsigned BN = OUT_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_qa;
  logic                 r_cfg_err;
  logic [CW-1:0]        r_fill;
  logic [OUT_WIDTH-1:0] r_pack;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic [BN-1:0]        r_out_strb;
  logic                 r_out_valid;
  logic                 r_out_last;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_out_fire;
  logic                 w_fill_last;
  logic                 w_complete;
  logic                 w_qa_ok;
  logic [SW-1:0]        w_fill_ext;
  logic [SW-1:0]        w_shamt;
  logic [SW-1:0]        w_nbytes;
  logic [OUT_WIDTH-1:0] w_elem;
  logic [OUT_WIDTH-1:0] w_merged;
  logic [BN-1:0]        w_strb;

  assign w_qa_ok    = (qa_out_i == 4'd2) || (qa_out_i == 4'd4) || (qa_out_i == 4'd8);
  assign w_accept   = in_valid_i & w_in_ready;
  assign w_out_fire = r_out_valid & out_ready_i;
  assign w_complete = w_accept & (w_fill_last | in_last_i);

  // Per-qa element extraction, bit offset, word-full test and byte count
  // of the word once the current element is merged.
  always_comb begin
    w_fill_ext  = SW'(r_fill);
    w_elem      = OUT_WIDTH'(in_data_i[7:0]);
    w_shamt     = w_fill_ext << 3;
    w_fill_last = (r_fill == CW'(OUT_WIDTH / 8 - 1));
    w_nbytes    = w_fill_ext + SW'(1);
    case (r_qa)
      4'd2: begin
        w_elem      = OUT_WIDTH'(in_data_i[1:0]);
        w_shamt     = w_fill_ext << 1;
        w_fill_last = (r_fill == CW'(OUT_WIDTH / 2 - 1));
        // ceil((fill+1)*2/8) == (fill+4)/4
        w_nbytes    = (w_fill_ext + SW'(4)) >> 2;
      end
      4'd4: begin
        w_elem      = OUT_WIDTH'(in_data_i[3:0]);
        w_shamt     = w_fill_ext << 2;
        w_fill_last = (r_fill == CW'(OUT_WIDTH / 4 - 1));
        // ceil((fill+1)*4/8) == (fill+2)/2
        w_nbytes    = (w_fill_ext + SW'(2)) >> 1;
      end
      default: begin
      end
    endcase
  end

  assign w_merged = r_pack | (w_elem << w_shamt);

  // Low w_nbytes strobe bits set; a full word naturally gives all ones.
  generate
    for (genvar gi = 0; gi < BN; gi++) begin : g_strb
      assign w_strb[gi] = (w_nbytes > SW'(gi));
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else if (clear_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and input-side ready.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_in_ready = ~r_out_valid | out_ready_i;
        if (w_accept && in_last_i) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_fire && r_out_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Latch qa at job start; unsupported values fall back to 8 and flag sticky.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_qa      <= 4'd8;
      r_cfg_err <= 1'b0;
    end else if (clear_i) begin
      r_qa      <= 4'd8;
      r_cfg_err <= 1'b0;
    end else if (r_state == S_IDLE && start_i) begin
      r_qa <= w_qa_ok ? qa_out_i : 4'd8;
      if (!w_qa_ok) begin
        r_cfg_err <= 1'b1;
      end
    end
  end

  // Assembly register and fill counter; both restart after a completed word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pack <= '0;
      r_fill <= '0;
    end else if (clear_i) begin
      r_pack <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_pack <= '0;
        r_fill <= '0;
      end else begin
        r_pack <= w_merged;
        r_fill <= r_fill + CW'(1);
      end
    end
  end

  // Output register: reload on word completion (even while draining), else
  // drop valid once the current word is taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_strb  <= '0;
      r_out_last  <= 1'b0;
    end else if (clear_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_strb  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_complete) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_merged;
      r_out_strb  <= w_strb;
      r_out_last  <= in_last_i;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef RBE_NORMQUANT_PACKER_OVF_EN
  logic r_ovf;
  logic w_hi_set;

  // Any set bit above the latched qa is an overflow of the quantizer range.
  always_comb begin
    case (r_qa)
      4'd2:    w_hi_set = |in_data_i[ACC-1:2];
      4'd4:    w_hi_set = |in_data_i[ACC-1:4];
      default: w_hi_set = |in_data_i[ACC-1:8];
    endcase
  end

  // Sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
    end else if (clear_i) begin
      r_ovf <= 1'b0;
    end else if (w_accept && w_hi_set) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf_o = r_ovf;
`else
  // Upper element bits are intentionally discarded in this build.
  logic w_unused_hi;
  assign w_unused_hi = ^in_data_i[ACC-1:8];
  assign ovf_o       = 1'b0;
`endif

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_strb_o  = r_out_strb;
  assign out_last_o  = r_out_last;
  assign busy_o      = (r_state != S_IDLE);
  assign cfg_err_o   = r_cfg_err;

endmodule

// File: tb/tb_rbe_normquant_packer.sv
// Scoreboard bench for rbe_normquant_packer: a job-level packing model fills
// an expected-word queue, a negedge monitor pops and compares each handshake.
module tb_rbe_normquant_packer;

  localparam int OW  = 32;
  localparam int ACC = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic            start;
  logic [3:0]      qa;
  logic            in_valid;
  logic            in_ready;
  logic [ACC-1:0]  in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;
  logic [OW/8-1:0] out_strb;
  logic            out_last;
  logic            busy;
  logic            cfg_err;
  logic            ovf;

  always #5 clk = ~clk;

  rbe_normquant_packer #(.ACC(ACC), .OUT_WIDTH(OW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .qa_out_i(qa), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_strb_o(out_strb),
    .out_last_o(out_last), .busy_o(busy), .cfg_err_o(cfg_err), .ovf_o(ovf)
  );

  typedef struct packed {
    logic [OW-1:0]   data;
    logic [OW/8-1:0] strb;
    logic            last;
  } word_t;

  word_t         exp_q[$];
  logic [31:0]   job_el[$];
  int            tests = 0;
  int            fails = 0;
  int            rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
  int            words_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: chunk the job into groups of OW/q elements, LSB-first.
  task automatic model_job(input int q);
    int          n;
    int          k;
    int          nb;
    logic [31:0] w;
    logic [31:0] m;
    word_t       e;
    n = OW / q;
    k = 0;
    w = 0;
    m = (32'd1 << q) - 32'd1;
    for (int i = 0; i < job_el.size(); i++) begin
      w = w | ((job_el[i] & m) << (k * q));
      k++;
      if (k == n || i == job_el.size() - 1) begin
        nb     = (k * q + 7) / 8;
        e.data = w;
        e.strb = 4'((1 << nb) - 1);
        e.last = (i == job_el.size() - 1);
        exp_q.push_back(e);
        w = 0;
        k = 0;
      end
    end
  endtask

  // Output backpressure driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: a word is consumed at the edge following a valid&ready sample.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      if (!rst && !clear && out_valid && out_ready) begin
        words_seen++;
        $display("[TB] word %0d data=0x%08h strb=0x%0h last=%0b", words_seen, out_data, out_strb, out_last);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_word: got 0x%0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("word_data", out_data, e.data);
          check("word_strb", 32'(out_strb), 32'(e.strb));
          check("word_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic start_job(input logic [3:0] q);
    wait_idle();
    start = 1'b1;
    qa    = q;
    @(posedge clk);
    #1;
    start = 1'b0;
    qa    = $urandom_range(15);
    check("in_ready_after_start", 32'(in_ready), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit acc = 0;
    int cyc = 0;
    if (rdy_mode == 0 && $urandom_range(3) == 0) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!acc && cyc < 500) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    if (!acc) begin
      tests++;
      fails++;
      $display("[TB] FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic run_job(input logic [3:0] qin, input int qeff, input int len);
    job_el.delete();
    for (int i = 0; i < len; i++) job_el.push_back($urandom);
    model_job(qeff);
    start_job(qin);
    for (int i = 0; i < len; i++) send(job_el[i], i == len - 1);
    wait_idle();
  endtask

  initial begin
    int cyc;
    int qsel;
    rst = 1'b1; clear = 1'b0; start = 1'b0; qa = 4'd0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_strb", 32'(out_strb), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // qa=8, four bytes, one full last word with one-cycle latency.
    rdy_mode = 1;
    job_el = '{32'h11, 32'h22, 32'h33, 32'h44};
    model_job(8);
    start_job(4'd8);
    for (int i = 0; i < 3; i++) send(job_el[i], 1'b0);
    check("no_word_before_4th", 32'(out_valid), 32'd0);
    send(job_el[3], 1'b1);
    check("latency_valid", 32'(out_valid), 32'd1);
    wait_idle();
    check("idle_after_job", 32'(busy), 32'd0);

    // qa=4: one full word then a 3-nibble partial last word.
    job_el = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA, 32'hB};
    model_job(4);
    start_job(4'd4);
    for (int i = 0; i < 11; i++) send(job_el[i], i == 10);
    wait_idle();

    // qa=2: full word under a 5-cycle output stall, then a 1-element tail.
    rdy_mode = 2;
    job_el.delete();
    for (int i = 0; i < 16; i++) job_el.push_back(32'h3);
    job_el.push_back(32'h1);
    model_job(2);
    start_job(4'd2);
    for (int i = 0; i < 16; i++) send(job_el[i], 1'b0);
    check("stall_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_data_stable", out_data, 32'hFFFF_FFFF);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    rdy_mode = 1;
    send(32'h1, 1'b1);
    wait_idle();

    // Unsupported qa falls back to 8 and sets a sticky flag.
    run_job(4'd5, 8, 6);
    check("cfg_err_set", 32'(cfg_err), 32'd1);
    run_job(4'd4, 4, 3);
    check("cfg_err_sticky", 32'(cfg_err), 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_cfg_err", 32'(cfg_err), 32'd0);
    check("clear_ovf", 32'(ovf), 32'd0);

    // Overflow: element 0x13 at qa=4 packs as nibble 0x3.
    job_el = '{32'h13};
    model_job(4);
    start_job(4'd4);
    send(32'h13, 1'b1);
`ifdef RBE_NORMQUANT_PACKER_OVF_EN
    check("ovf_flag", 32'(ovf), 32'd1);
`else
    check("ovf_flag", 32'(ovf), 32'd0);
`endif
    wait_idle();

    // Reset mid-job drops partial data; the next job starts clean.
    start_job(4'd8);
    send(32'hAA, 1'b0);
    send(32'hBB, 1'b0);
    send(32'hCC, 1'b0);
    rst = 1'b1;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    job_el = '{32'h01, 32'h02, 32'h03, 32'h04};
    model_job(8);
    start_job(4'd8);
    for (int i = 0; i < 4; i++) send(job_el[i], i == 3);
    wait_idle();

    // Randomized jobs with random backpressure and full-width element data.
    rdy_mode = 0;
    for (int j = 0; j < 10; j++) begin
      qsel = $urandom_range(2);
      case (qsel)
        0:       run_job(4'd2, 2, $urandom_range(1, 40));
        1:       run_job(4'd4, 4, $urandom_range(1, 40));
        default: run_job(4'd8, 8, $urandom_range(1, 40));
      endcase
    end

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
